// File: rtl/mwc_pkg.sv
// Shared types, default parameters and helpers for the memory-write checker.
package mwc_pkg;

    localparam int MWC_DW    = 32;
    localparam int MWC_AW    = 16;
    localparam int MWC_NEXP  = 4;
    localparam int MWC_PCW   = 32;
    localparam int MWC_TMO   = 1024;
    localparam int MWC_PTR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } mwc_state_t;

    // Lowest set bit of v at or above position from; 16 means none left.
    function automatic logic [MWC_PTR_W-1:0] first_valid_from(input logic [15:0] v,
                                                             input logic [MWC_PTR_W-1:0] from);
        first_valid_from = MWC_PTR_W'(16);
        for (int i = 15; i >= 0; i--) begin
            if (MWC_PTR_W'(i) >= from && v[i]) first_valid_from = MWC_PTR_W'(i);
        end
    endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// CPU data-memory write port as seen by the checker (CPU is master, checker is slave).
interface mem_write_checker_if #(
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int PCW = 32
) ();
    logic           memwrite;
    logic [AW-1:0]  dataadr;
    logic [DW-1:0]  writedata;
    logic [PCW-1:0] pc;

    modport master (output memwrite, dataadr, writedata, pc);
    modport slave  (input  memwrite, dataadr, writedata, pc);
endinterface

// File: rtl/mwc_match.sv
// Combinational compare of one write against the expected table, lowest index wins.
module mwc_match #(
    parameter int DW   = 32,
    parameter int AW   = 16,
    parameter int NEXP = 4
) (
    input  logic [NEXP-1:0]    valid,
    input  logic [NEXP-1:0]    eligible,
    input  logic [NEXP*AW-1:0] tbl_addr,
    input  logic [NEXP*DW-1:0] tbl_data,
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      data,
    output logic               hit,
    output logic [4:0]         hit_idx,
    output logic [NEXP-1:0]    hit_onehot,
    output logic               addr_hit
);

    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        addr_hit   = 1'b0;
        // Walk downwards so the lowest matching index is the last one written.
        for (int i = NEXP - 1; i >= 0; i--) begin
            if (valid[i] && tbl_addr[i*AW +: AW] == addr) addr_hit = 1'b1;
            if (eligible[i] && tbl_addr[i*AW +: AW] == addr && tbl_data[i*DW +: DW] == data) begin
                hit     = 1'b1;
                hit_idx = 5'(i);
            end
        end
        for (int i = 0; i < NEXP; i++) begin
            hit_onehot[i] = hit && (hit_idx == 5'(i));
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Watches CPU data-memory writes against a latched table of expected writes and
// reports pass/fail once all are seen, a bad write occurs, or time/pc runs out.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int DW      = MWC_DW,
    parameter int AW      = MWC_AW,
    parameter int NEXP    = MWC_NEXP,
    parameter int PCW     = MWC_PCW,
    parameter bit ORDERED = 1'b0,
    parameter bit STRICT  = 1'b0,
    parameter int TMO     = MWC_TMO
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    mem_write_checker_if.slave  bus,
    input  logic [PCW-1:0]      pc_limit,
    input  logic [NEXP-1:0]     exp_valid,
    input  logic [NEXP*AW-1:0]  exp_addr,
    input  logic [NEXP*DW-1:0]  exp_data,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [NEXP-1:0]     match_mask,
    output logic [7:0]          stray_count,
    output logic [AW-1:0]       err_addr
);

    localparam logic [16:0] TMO_LIM = 17'(TMO);

    mwc_state_t           state;
    logic [NEXP-1:0]      tbl_valid;
    logic [NEXP*AW-1:0]   tbl_addr;
    logic [NEXP*DW-1:0]   tbl_data;
    logic [15:0]          cyc_cnt;
    logic [MWC_PTR_W-1:0] ptr;

    logic [NEXP-1:0] ptr_sel, eligible, hit_onehot, next_mask;
    logic [4:0]      hit_idx;
    logic            hit, addr_hit, wr, complete, wr_fail, stray, tmo_hit, limit_hit;

    always_comb begin
        ptr_sel = '0;
        for (int i = 0; i < NEXP; i++) ptr_sel[i] = (ptr == MWC_PTR_W'(i));
    end

    // In ordered mode only the entry under the pointer may be matched.
    assign eligible = ORDERED ? (tbl_valid & ~match_mask & ptr_sel) : (tbl_valid & ~match_mask);

    mwc_match #(.DW(DW), .AW(AW), .NEXP(NEXP)) u_match (
        .valid      (tbl_valid),
        .eligible   (eligible),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .addr       (bus.dataadr),
        .data       (bus.writedata),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_onehot (hit_onehot),
        .addr_hit   (addr_hit)
    );

    assign wr        = bus.memwrite;
    assign next_mask = match_mask | (wr ? hit_onehot : '0);
    assign complete  = ((tbl_valid & ~next_mask) == '0);
    assign wr_fail   = wr && !hit && (addr_hit || STRICT);
    assign stray     = wr && !addr_hit;
    assign tmo_hit   = ({1'b0, cyc_cnt} + 17'd1) >= TMO_LIM;
    assign limit_hit = tmo_hit || (bus.pc > pc_limit);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            // NOTE: the table is a handful of flops, not a RAM, so clearing it on reset is cheap and intended.
            tbl_valid   <= '0;
            tbl_addr    <= '0;
            tbl_data    <= '0;
            cyc_cnt     <= '0;
            ptr         <= '0;
            match_mask  <= '0;
            stray_count <= '0;
            err_addr    <= '0;
        end else begin
            case (state)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        tbl_valid   <= exp_valid;
                        tbl_addr    <= exp_addr;
                        tbl_data    <= exp_data;
                        cyc_cnt     <= '0;
                        ptr         <= first_valid_from(16'(exp_valid), '0);
                        match_mask  <= '0;
                        stray_count <= '0;
                        err_addr    <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    cyc_cnt <= cyc_cnt + 16'd1;
                    if (wr && hit) begin
                        match_mask <= next_mask;
                        if (ORDERED) ptr <= first_valid_from(16'(tbl_valid), hit_idx + 5'd1);
                    end
                    if (stray && stray_count != 8'hFF) stray_count <= stray_count + 8'd1;
                    if (complete) begin
                        state <= PASS;
                    end else if (wr_fail) begin
                        state    <= FAIL;
                        err_addr <= bus.dataadr;
                    end else if (limit_hit) begin
                        state <= FAIL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == PASS) || (state == FAIL);
    assign pass = (state == PASS);
    assign fail = (state == FAIL);

endmodule

// File: tb/tb_mem_write_checker.sv
// Randomized scoreboard bench: three checker variants (plain, ordered, strict) share one write stream.
module tb_mem_write_checker;

    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int NEXP = 4;
    localparam int PCW  = 32;
    localparam int TMO  = 40;
    localparam int NCFG = 3;
    localparam int L    = TMO + 4;

    typedef struct {
        bit              pass;
        logic [NEXP-1:0] mask;
        logic [7:0]      stray;
        logic [AW-1:0]   err;
        longint          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [PCW-1:0]     pc_limit = '1;
    logic [NEXP-1:0]    exp_valid = '0;
    logic [NEXP*AW-1:0] exp_addr = '0;
    logic [NEXP*DW-1:0] exp_data = '0;

    logic            busy_o [NCFG];
    logic            done_o [NCFG];
    logic            pass_o [NCFG];
    logic            fail_o [NCFG];
    logic [NEXP-1:0] mask_o [NCFG];
    logic [7:0]      stray_o[NCFG];
    logic [AW-1:0]   err_o  [NCFG];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    // Run description consumed by both the driver and the reference model.
    bit            t_valid[NEXP];
    logic [AW-1:0] t_addr [NEXP];
    logic [DW-1:0] t_data [NEXP];
    logic [PCW-1:0] t_limit;
    bit             w_en  [L];
    logic [AW-1:0]  w_addr[L];
    logic [DW-1:0]  w_data[L];
    logic [PCW-1:0] w_pc  [L];

    exp_t sb_q[NCFG][$];
    exp_t cur [NCFG];
    logic done_q[NCFG];

    mem_write_checker_if #(.AW(AW), .DW(DW), .PCW(PCW)) bus ();

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        mem_write_checker #(
            .DW(DW), .AW(AW), .NEXP(NEXP), .PCW(PCW),
            .ORDERED(g == 1), .STRICT(g == 2), .TMO(TMO)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start),
            .bus         (bus.slave),
            .pc_limit    (pc_limit),
            .exp_valid   (exp_valid),
            .exp_addr    (exp_addr),
            .exp_data    (exp_data),
            .busy        (busy_o[g]),
            .done        (done_o[g]),
            .pass        (pass_o[g]),
            .fail        (fail_o[g]),
            .match_mask  (mask_o[g]),
            .stray_count (stray_o[g]),
            .err_addr    (err_o[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: walk the run write by write applying the matching rules directly.
    function automatic exp_t model(input bit ordered, input bit strict, output int k_end);
        exp_t e;
        bit   m[NEXP];
        int   cand, nxt;
        bit   in_tbl, outstanding, fin;
        e     = '{pass: 1'b0, mask: '0, stray: '0, err: '0, cyc: 0};
        k_end = L - 1;
        for (int i = 0; i < NEXP; i++) m[i] = 1'b0;
        for (int k = 0; k < L; k++) begin
            cand   = -1;
            in_tbl = 1'b0;
            fin    = 1'b0;
            if (w_en[k]) begin
                for (int i = 0; i < NEXP; i++)
                    if (t_valid[i] && t_addr[i] == w_addr[k]) in_tbl = 1'b1;
                if (!ordered) begin
                    for (int i = 0; i < NEXP; i++)
                        if (cand < 0 && t_valid[i] && !m[i] && t_addr[i] == w_addr[k] && t_data[i] == w_data[k])
                            cand = i;
                end else begin
                    nxt = -1;
                    for (int i = 0; i < NEXP; i++)
                        if (nxt < 0 && t_valid[i] && !m[i]) nxt = i;
                    if (nxt >= 0 && t_addr[nxt] == w_addr[k] && t_data[nxt] == w_data[k]) cand = nxt;
                end
                if (cand >= 0) m[cand] = 1'b1;
                if (!in_tbl && e.stray != 8'd255) e.stray = e.stray + 8'd1;
            end
            outstanding = 1'b0;
            for (int i = 0; i < NEXP; i++)
                if (t_valid[i] && !m[i]) outstanding = 1'b1;
            if (!outstanding) begin
                e.pass = 1'b1;
                fin    = 1'b1;
            end else if (w_en[k] && cand < 0 && (in_tbl || strict)) begin
                e.err = w_addr[k];
                fin   = 1'b1;
            end else if (k + 1 >= TMO || w_pc[k] > t_limit) begin
                fin = 1'b1;
            end
            if (fin) begin
                for (int i = 0; i < NEXP; i++) e.mask[i] = m[i];
                k_end = k;
                return e;
            end
        end
        return e;
    endfunction

    task automatic bus_idle();
        bus.memwrite  = 1'b0;
        bus.dataadr   = '0;
        bus.writedata = '0;
    endtask

    task automatic load_table();
        for (int i = 0; i < NEXP; i++) begin
            exp_valid[i]          = t_valid[i];
            exp_addr[i*AW +: AW]  = t_addr[i];
            exp_data[i*DW +: DW]  = t_data[i];
        end
        pc_limit = t_limit;
    endtask

    // Issue one run: predict each variant, queue predictions, then play the write stream.
    task automatic run_one(input bit mid_start);
        exp_t e;
        int   ke;
        int   min_end;
        int   ms;
        min_end = L;
        @(posedge clk); #1;
        for (int c = 0; c < NCFG; c++) begin
            e     = model(c == 1, c == 2, ke);
            e.cyc = cyc + 2 + ke;
            sb_q[c].push_back(e);
            if (ke < min_end) min_end = ke;
        end
        ms = mid_start ? $urandom_range(0, min_end) : -1;
        load_table();
        bus_idle();
        start = 1'b1;
        @(posedge clk); #1;
        exp_valid = NEXP'($urandom);
        exp_addr  = {2{$urandom}};
        exp_data  = {4{$urandom}};
        for (int k = 0; k < L; k++) begin
            start         = (k == ms);
            bus.memwrite  = w_en[k];
            bus.dataadr   = w_addr[k];
            bus.writedata = w_data[k];
            bus.pc        = w_pc[k];
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus_idle();
    endtask

    task automatic set_t1();
        for (int i = 0; i < NEXP; i++) begin
            t_valid[i] = 1'b0;
            t_addr[i]  = '0;
            t_data[i]  = '0;
        end
        t_valid[0] = 1'b1; t_addr[0] = 16'd1;  t_data[0] = 32'h0C0C_000A;
        t_valid[1] = 1'b1; t_addr[1] = 16'd63; t_data[1] = 32'h0000_0000;
        t_limit = '1;
        for (int k = 0; k < L; k++) begin
            w_en[k]   = 1'b0;
            w_addr[k] = 16'(k * 7);
            w_data[k] = 32'(k);
            w_pc[k]   = PCW'(4 * k);
        end
    endtask

    task automatic put_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_en[k]   = 1'b1;
        w_addr[k] = a;
        w_data[k] = d;
    endtask

    task automatic gen_random();
        int r, i, base;
        for (int j = 0; j < NEXP; j++) begin
            t_valid[j] = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: t_addr[j] = 16'h0000;
                1: t_addr[j] = 16'h0001;
                2: t_addr[j] = 16'h0002;
                3: t_addr[j] = 16'h0003;
                4: t_addr[j] = 16'h8001;
                default: t_addr[j] = 16'hFFFF;
            endcase
            t_data[j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
        end
        t_limit = ($urandom_range(0, 3) == 0) ? PCW'($urandom_range(0, 200)) : '1;
        base    = $urandom_range(0, 50);
        for (int k = 0; k < L; k++) begin
            r         = $urandom_range(0, 99);
            i         = $urandom_range(0, NEXP - 1);
            w_en[k]   = (r >= 40);
            w_addr[k] = 16'($urandom);
            w_data[k] = $urandom;
            w_pc[k]   = PCW'(base + 4 * k);
            if (r >= 40 && r < 75) begin
                w_addr[k] = t_addr[i];
                w_data[k] = t_data[i];
            end else if (r >= 75 && r < 85) begin
                w_addr[k] = t_addr[i];
                w_data[k] = 32'($urandom_range(0, 3));
            end else if (r >= 85) begin
                w_addr[k] = 16'h4000 | 16'($urandom_range(0, 3));
            end
        end
    endtask

    // Monitor: pop a prediction whenever a checker reports done, then watch it hold.
    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < NCFG; c++) begin
            if (done_o[c] && !done_q[c]) begin
                if (sb_q[c].size() == 0) begin
                    check($sformatf("c%0d_unexpected_done", c), 64'd1, 64'd0);
                end else begin
                    e = sb_q[c].pop_front();
                    cur[c] <= e;
                    check($sformatf("c%0d_done_cycle", c), 64'(cyc), 64'(e.cyc));
                    check($sformatf("c%0d_pass", c), 64'(pass_o[c]), 64'(e.pass));
                    check($sformatf("c%0d_fail", c), 64'(fail_o[c]), 64'(!e.pass));
                    check($sformatf("c%0d_mask", c), 64'(mask_o[c]), 64'(e.mask));
                    check($sformatf("c%0d_stray", c), 64'(stray_o[c]), 64'(e.stray));
                    check($sformatf("c%0d_err_addr", c), 64'(err_o[c]), 64'(e.err));
                end
            end else if (done_o[c] && done_q[c]) begin
                check($sformatf("c%0d_hold", c),
                      {pass_o[c], mask_o[c], stray_o[c], err_o[c]},
                      {cur[c].pass, cur[c].mask, cur[c].stray, cur[c].err});
            end
            done_q[c] <= done_o[c];
        end
    end

    initial begin
        for (int c = 0; c < NCFG; c++) done_q[c] = 1'b0;
        bus_idle();
        bus.pc = '0;
        #12;
        for (int c = 0; c < NCFG; c++)
            check($sformatf("c%0d_reset_outputs", c),
                  {busy_o[c], done_o[c], pass_o[c], fail_o[c], mask_o[c], stray_o[c], err_o[c]}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        for (int c = 0; c < NCFG; c++)
            check($sformatf("c%0d_idle_after_reset", c), {busy_o[c], done_o[c]}, '0);

        // Listed table, reversed order writes.
        set_t1();
        put_wr(0, 16'd63, 32'h0);
        put_wr(1, 16'd1, 32'h0C0C_000A);
        run_one(1'b0);

        // Wrong data on a listed address.
        set_t1();
        put_wr(0, 16'd1, 32'h0C0C_000B);
        run_one(1'b0);

        // Strays ahead of the expected writes.
        set_t1();
        put_wr(0, 16'd20, 32'h5);
        put_wr(1, 16'd20, 32'h6);
        put_wr(2, 16'd1, 32'h0C0C_000A);
        put_wr(3, 16'd63, 32'h0);
        run_one(1'b0);

        // pc passes its limit with one entry outstanding.
        set_t1();
        t_limit = 100;
        put_wr(0, 16'd1, 32'h0C0C_000A);
        run_one(1'b0);

        // Completing write lands in the same cycle pc passes the limit.
        set_t1();
        t_limit = 100;
        put_wr(0, 16'd1, 32'h0C0C_000A);
        put_wr(26, 16'd63, 32'h0);
        run_one(1'b0);

        // Timeout with nothing written.
        set_t1();
        run_one(1'b1);

        // Reset mid-run after one match.
        set_t1();
        @(posedge clk); #1;
        load_table();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.memwrite  = 1'b1;
        bus.dataadr   = 16'd1;
        bus.writedata = 32'h0C0C_000A;
        bus.pc        = '0;
        @(posedge clk); #1;
        bus_idle();
        for (int c = 0; c < NCFG; c++)
            check($sformatf("c%0d_midrun_state", c), {busy_o[c], mask_o[c]}, {1'b1, 4'b0001});
        #2;
        reset = 1'b0;
        #1;
        for (int c = 0; c < NCFG; c++)
            check($sformatf("c%0d_async_reset", c),
                  {busy_o[c], done_o[c], pass_o[c], fail_o[c], mask_o[c], stray_o[c], err_o[c]}, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Empty table: pass right after entering RUN.
        set_t1();
        for (int i = 0; i < NEXP; i++) t_valid[i] = 1'b0;
        run_one(1'b0);

        for (int n = 0; n < 50; n++) begin
            gen_random();
            run_one(n[0]);
        end

        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < NCFG; c++)
            check($sformatf("c%0d_scoreboard_empty", c), 64'(sb_q[c].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
